// File: rtl/ifetch_pq.sv
// Instruction prefetch queue: streams halfwords from a shared single-port memory into a
// small FIFO for decode. Define IFETCH_ALIGN_CHECK_EN to trap odd branch targets.
module ifetch_pq #(
  parameter int MEM_DEPTH   = 2**12,
  parameter int QUEUE_DEPTH = 4,
  parameter int RESET_PC    = 0,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_rd_en,
  input  logic [15:0]           i_mem_do,
  input  logic                  i_dmem_req,
  input  logic                  i_branch,
  input  logic [ADDR_WIDTH-1:0] i_branch_addr,
  output logic [15:0]           o_ir,
  output logic [ADDR_WIDTH-1:0] o_ir_pc,
  output logic                  o_ir_valid,
  input  logic                  i_ir_ready,
  output logic                  o_fault
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [CW:0]           DEPTH_C    = (CW+1)'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_RST     = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(1));

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [CW-1:0]         count;
  logic [CW:0]           credits_used;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  inflight;
  logic                  fault;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  head_valid;

  logic [15:0]           q_ir [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc [QUEUE_DEPTH];

  // Odd targets are forced even; with the align check on they also raise the fault.
  assign branch_target = i_branch_addr & ALIGN_MASK;

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (i_branch && i_branch_addr[0]) begin
      fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

  // A read in flight already owns a queue slot, so it counts against the credit.
  assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue        = !rst && !i_branch && !i_dmem_req && !fault && (credits_used < DEPTH_C);
  assign head_valid   = (count != '0);
  assign push         = inflight && !i_branch;
  assign pop          = head_valid && i_ir_ready && !i_branch;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= PC_RST;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (i_branch) begin
      fetch_pc <= branch_target;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_STEP;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; head_valid qualifies every read of it.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_ir[wr_ptr] <= i_mem_do;
      q_pc[wr_ptr] <= inflight_pc;
    end
  end

  assign o_mem_en    = issue;
  assign o_mem_rd_en = issue;
  assign o_mem_addr  = issue ? fetch_pc : '0;

  assign o_ir_valid  = !rst && head_valid;
  assign o_ir        = o_ir_valid ? q_ir[rd_ptr] : '0;
  assign o_ir_pc     = o_ir_valid ? q_pc[rd_ptr] : '0;
  assign o_fault     = !rst && fault;

endmodule

// File: tb/tb_ifetch_pq.sv
// Scoreboard bench for ifetch_pq: expected fetch addresses are queued as fetches are
// expected to issue and checked, with their data, as decode consumes the queue head.
module tb_ifetch_pq;
  localparam int MEM_DEPTH = 2**12;
  localparam int QD        = 4;
  localparam int RPC       = 'h10;
  localparam int AW        = $clog2(MEM_DEPTH*2);
  typedef logic [AW-1:0] addr_t;

  logic        clk = 1'b0;
  logic        rst;
  addr_t       o_mem_addr;
  logic        o_mem_en, o_mem_rd_en;
  logic [15:0] i_mem_do;
  logic        i_dmem_req, i_branch, i_ir_ready;
  addr_t       i_branch_addr;
  logic [15:0] o_ir;
  addr_t       o_ir_pc;
  logic        o_ir_valid, o_fault;

  always #5 clk = ~clk;

  ifetch_pq #(.MEM_DEPTH(MEM_DEPTH), .QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .o_mem_addr(o_mem_addr), .o_mem_en(o_mem_en),
    .o_mem_rd_en(o_mem_rd_en), .i_mem_do(i_mem_do), .i_dmem_req(i_dmem_req),
    .i_branch(i_branch), .i_branch_addr(i_branch_addr), .o_ir(o_ir), .o_ir_pc(o_ir_pc),
    .o_ir_valid(o_ir_valid), .i_ir_ready(i_ir_ready), .o_fault(o_fault)
  );

  function automatic logic [15:0] data_of(input addr_t a);
    logic [15:0] x;
    x = 16'(a);
    return (x * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Memory model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) i_mem_do <= o_mem_rd_en ? data_of(o_mem_addr) : 16'($urandom);

  int    vec  = 0;
  int    miss = 0;
  addr_t sb[$];

  logic        s_en, s_rd, s_valid, s_fault;
  addr_t       s_addr, s_pc;
  logic [15:0] s_ir;

  task automatic step(input logic rdy, input logic dm, input logic br, input addr_t ba);
    i_ir_ready = rdy; i_dmem_req = dm; i_branch = br; i_branch_addr = ba;
    #1;
    s_en = o_mem_en; s_rd = o_mem_rd_en; s_addr = o_mem_addr;
    s_valid = o_ir_valid; s_ir = o_ir; s_pc = o_ir_pc; s_fault = o_fault;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, (c == 1), addr_t'('h40));
      vec++;
      if ({s_en, s_rd, s_valid, s_fault} !== 4'b0 || s_addr !== '0 || s_ir !== '0 || s_pc !== '0) begin
        miss++;
        $display("FAIL reset_outputs cyc %0d: en=%b rd=%b valid=%b fault=%b addr=%h ir=%h pc=%h, want all 0",
                 c, s_en, s_rd, s_valid, s_fault, s_addr, s_ir, s_pc);
      end
    end
  endtask

  task automatic test_stream();
    addr_t exp_addr = addr_t'(RPC);
    addr_t exp_pc;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      vec++;
      if (s_en !== 1'b1 || s_rd !== 1'b1 || s_addr !== exp_addr) begin
        miss++;
        $display("FAIL stream_fetch cyc %0d: en=%b rd=%b addr=%h, want 1 1 %h", c, s_en, s_rd, s_addr, exp_addr);
      end
      sb.push_back(exp_addr); exp_addr += 2;
      vec++;
      if (s_valid !== 1'(c >= 2)) begin
        miss++;
        $display("FAIL stream_valid cyc %0d: valid=%b, want %b", c, s_valid, (c >= 2));
      end
      if (s_valid === 1'b1) begin
        vec++;
        if (sb.size() == 0) begin
          miss++; $display("FAIL stream_deliver cyc %0d: pc=%h with nothing expected", c, s_pc);
        end else begin
          exp_pc = sb.pop_front();
          if (s_pc !== exp_pc || s_ir !== data_of(exp_pc)) begin
            miss++;
            $display("FAIL stream_deliver cyc %0d: pc=%h ir=%h, want %h %h", c, s_pc, s_ir, exp_pc, data_of(exp_pc));
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    addr_t exp_addr = addr_t'(RPC);
    addr_t exp_pc;
    logic  rdy, want_en;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      rdy = (c >= 8);
      want_en = (c < 4) || (c >= 9);
      step(rdy, 1'b0, 1'b0, '0);
      vec++;
      if (s_en !== want_en || s_rd !== want_en || s_addr !== (want_en ? exp_addr : addr_t'(0))) begin
        miss++;
        $display("FAIL bp_fetch cyc %0d: en=%b rd=%b addr=%h, want %b %b %h", c, s_en, s_rd, s_addr,
                 want_en, want_en, want_en ? exp_addr : addr_t'(0));
      end
      if (want_en) begin sb.push_back(exp_addr); exp_addr += 2; end
      if (c == 7) begin
        vec++;
        if (s_valid !== 1'b1 || s_pc !== addr_t'(RPC)) begin
          miss++; $display("FAIL bp_hold: valid=%b pc=%h, want 1 %h", s_valid, s_pc, addr_t'(RPC));
        end
      end
      if (s_valid === 1'b1 && rdy) begin
        vec++;
        if (sb.size() == 0) begin
          miss++; $display("FAIL bp_deliver cyc %0d: pc=%h with nothing expected", c, s_pc);
        end else begin
          exp_pc = sb.pop_front();
          if (s_pc !== exp_pc || s_ir !== data_of(exp_pc)) begin
            miss++;
            $display("FAIL bp_deliver cyc %0d: pc=%h ir=%h, want %h %h", c, s_pc, s_ir, exp_pc, data_of(exp_pc));
          end
        end
      end
    end
  endtask

  task automatic test_branch();
    addr_t exp_addr = addr_t'(RPC);
    addr_t exp_pc;
    logic  rdy, br, want_en;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      rdy = (c >= 4);
      br = (c == 4);
      want_en = (c != 4);
      step(rdy, 1'b0, br, addr_t'('h40));
      vec++;
      if (s_en !== want_en || s_rd !== want_en || s_addr !== (want_en ? exp_addr : addr_t'(0))) begin
        miss++;
        $display("FAIL br_fetch cyc %0d: en=%b rd=%b addr=%h, want %b %b %h", c, s_en, s_rd, s_addr,
                 want_en, want_en, want_en ? exp_addr : addr_t'(0));
      end
      if (want_en) begin sb.push_back(exp_addr); exp_addr += 2; end
      if (c >= 4 && c <= 7) begin
        vec++;
        if (s_valid !== 1'(c == 4 || c == 7)) begin
          miss++; $display("FAIL br_valid cyc %0d: valid=%b, want %b", c, s_valid, (c == 4 || c == 7));
        end
      end
      if (br) begin
        sb.delete(); exp_addr = addr_t'('h40);
      end else if (s_valid === 1'b1 && rdy) begin
        vec++;
        if (sb.size() == 0) begin
          miss++; $display("FAIL br_deliver cyc %0d: stale pc=%h", c, s_pc);
        end else begin
          exp_pc = sb.pop_front();
          if (s_pc !== exp_pc || s_ir !== data_of(exp_pc)) begin
            miss++;
            $display("FAIL br_deliver cyc %0d: pc=%h ir=%h, want %h %h", c, s_pc, s_ir, exp_pc, data_of(exp_pc));
          end
        end
      end
    end
  endtask

  task automatic test_dmem();
    addr_t exp_addr = addr_t'(RPC);
    addr_t exp_pc;
    logic  dm;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      dm = (c >= 5 && c <= 7);
      step(1'b1, dm, 1'b0, '0);
      vec++;
      if (s_en !== !dm || s_rd !== !dm || s_addr !== (dm ? addr_t'(0) : exp_addr)) begin
        miss++;
        $display("FAIL dmem_fetch cyc %0d: en=%b rd=%b addr=%h, want %b %b %h", c, s_en, s_rd, s_addr,
                 !dm, !dm, dm ? addr_t'(0) : exp_addr);
      end
      if (!dm) begin sb.push_back(exp_addr); exp_addr += 2; end
      if (c == 6) begin
        vec++;
        if (s_valid !== 1'b1) begin
          miss++; $display("FAIL dmem_inflight: valid=%b, want 1", s_valid);
        end
      end
      if (s_valid === 1'b1) begin
        vec++;
        if (sb.size() == 0) begin
          miss++; $display("FAIL dmem_deliver cyc %0d: pc=%h with nothing expected", c, s_pc);
        end else begin
          exp_pc = sb.pop_front();
          if (s_pc !== exp_pc || s_ir !== data_of(exp_pc)) begin
            miss++;
            $display("FAIL dmem_deliver cyc %0d: pc=%h ir=%h, want %h %h", c, s_pc, s_ir, exp_pc, data_of(exp_pc));
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    addr_t exp_addr = addr_t'(RPC);
    addr_t exp_pc;
    logic  br;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      br = (c == 3);
      step(1'b1, 1'b0, br, addr_t'('h1FFC));
      vec++;
      if (s_en !== !br || s_addr !== (br ? addr_t'(0) : exp_addr)) begin
        miss++;
        $display("FAIL wrap_fetch cyc %0d: en=%b addr=%h, want %b %h", c, s_en, s_addr, !br, br ? addr_t'(0) : exp_addr);
      end
      if (!br) begin sb.push_back(exp_addr); exp_addr += 2; end
      if (br) begin
        sb.delete(); exp_addr = addr_t'('h1FFC);
      end else if (s_valid === 1'b1) begin
        vec++;
        if (sb.size() == 0) begin
          miss++; $display("FAIL wrap_deliver cyc %0d: stale pc=%h", c, s_pc);
        end else begin
          exp_pc = sb.pop_front();
          if (s_pc !== exp_pc || s_ir !== data_of(exp_pc)) begin
            miss++;
            $display("FAIL wrap_deliver cyc %0d: pc=%h ir=%h, want %h %h", c, s_pc, s_ir, exp_pc, data_of(exp_pc));
          end
        end
      end
    end
  endtask

`ifdef IFETCH_ALIGN_CHECK_EN
  task automatic test_align();
    logic br;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      br = (c == 3);
      step(1'b1, 1'b0, br, addr_t'('h41));
      vec++;
      if (s_en !== 1'(c < 3) || s_fault !== 1'(c >= 4) || (c >= 4 && s_valid !== 1'b0)) begin
        miss++;
        $display("FAIL align_fault cyc %0d: en=%b fault=%b valid=%b, want %b %b %b", c, s_en, s_fault,
                 s_valid, (c < 3), (c >= 4), (c < 4) ? s_valid : 1'b0);
      end
    end
    apply_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    vec++;
    if (s_fault !== 1'b0 || s_en !== 1'b1 || s_addr !== addr_t'(RPC)) begin
      miss++;
      $display("FAIL align_clear: fault=%b en=%b addr=%h, want 0 1 %h", s_fault, s_en, s_addr, addr_t'(RPC));
    end
  endtask
`else
  task automatic test_align();
    addr_t exp_addr = addr_t'(RPC);
    addr_t exp_pc;
    logic  br;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      br = (c == 3);
      step(1'b1, 1'b0, br, addr_t'('h41));
      vec++;
      if (s_fault !== 1'b0 || s_en !== !br || s_addr !== (br ? addr_t'(0) : exp_addr)) begin
        miss++;
        $display("FAIL align_ignore cyc %0d: fault=%b en=%b addr=%h, want 0 %b %h", c, s_fault, s_en, s_addr,
                 !br, br ? addr_t'(0) : exp_addr);
      end
      if (!br) begin sb.push_back(exp_addr); exp_addr += 2; end
      if (br) begin
        sb.delete(); exp_addr = addr_t'('h40);
      end else if (s_valid === 1'b1) begin
        vec++;
        if (sb.size() == 0) begin
          miss++; $display("FAIL align_deliver cyc %0d: stale pc=%h", c, s_pc);
        end else begin
          exp_pc = sb.pop_front();
          if (s_pc !== exp_pc || s_ir !== data_of(exp_pc)) begin
            miss++;
            $display("FAIL align_deliver cyc %0d: pc=%h ir=%h, want %h %h", c, s_pc, s_ir, exp_pc, data_of(exp_pc));
          end
        end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; i_dmem_req = 1'b0; i_branch = 1'b0; i_ir_ready = 1'b0; i_branch_addr = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_dmem();
    test_wrap();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
